and2_bist_ctrl: RTL and testbench

Built-in self-test sequencer for a bank of `N_CELLS` 2-input AND standard cells (gf180mcu 9T library) placed on a test macro. On request it drives every cell with the exhaustive input sequence 00, 01, 10, 11 for a programmable number of passes. After a fixed settle window at each vector it samples the outputs, compares them against A&B, and accumulates mismatches. It returns a one-cycle done pulse with pass/fail status and a saturating error count. It sits between the chip's scan/test register file and the cell bank under test.

---
 rtl/and2_bist_ctrl.sv | 148 ++++++++++++++
 tb/tb_and2_bist_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/and2_bist_ctrl.sv
// Exhaustive 00/01/10/11 self-test sequencer for a bank of AND2 cells.
// Define AND2_BIST_FAILCAP_EN to add first-failure capture ports (fail_vec, fail_mask).
module and2_bist_ctrl #(
  parameter int N_CELLS    = 8,
  parameter int SETTLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               start,
  input  logic [7:0]         loops,
  output logic [N_CELLS-1:0] dut_a,
  output logic [N_CELLS-1:0] dut_b,
  input  logic [N_CELLS-1:0] dut_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt
`ifdef AND2_BIST_FAILCAP_EN
  ,
  output logic [1:0]         fail_vec,
  output logic [N_CELLS-1:0] fail_mask
`endif
);

  localparam int CW = $clog2(N_CELLS + 1);
  localparam int SW = ERR_W + CW;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t             r_state;
  logic [7:0]         r_loops;
  logic [1:0]         r_vec;
  logic [7:0]         r_set;
  logic [N_CELLS-1:0] r_dut_a, r_dut_b;
  logic               r_busy, r_done, r_pass;
  logic [ERR_W-1:0]   r_err_cnt;

  logic [N_CELLS-1:0] w_mismatch;
  logic [CW-1:0]      w_popcnt;
  logic [SW-1:0]      w_sum;
  logic [ERR_W-1:0]   w_err_next;

  assign w_mismatch = dut_y ^ {N_CELLS{r_vec[1] & r_vec[0]}};

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < N_CELLS; i++) w_popcnt = w_popcnt + CW'(w_mismatch[i]);
  end

  assign w_sum      = SW'(r_err_cnt) + SW'(w_popcnt);
  assign w_err_next = (w_sum > SW'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];

`ifdef AND2_BIST_FAILCAP_EN
  logic               r_cap_done;
  logic [1:0]         r_fail_vec;
  logic [N_CELLS-1:0] r_fail_mask;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cap_done  <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_cap_done  <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else if (r_state == S_CHECK && !r_cap_done && (|w_mismatch)) begin
      r_cap_done  <= 1'b1;
      r_fail_vec  <= r_vec;
      r_fail_mask <= w_mismatch;
    end
  end

  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_loops   <= '0;
      r_vec     <= '0;
      r_set     <= '0;
      r_dut_a   <= '0;
      r_dut_b   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dut_a <= '0;
          r_dut_b <= '0;
          if (start) begin
            r_loops   <= (loops == 8'd0) ? 8'd1 : loops;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
            r_vec     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_dut_a <= {N_CELLS{r_vec[1]}};
          r_dut_b <= {N_CELLS{r_vec[0]}};
          r_set   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_set == 8'(SETTLE_CYC - 1)) r_state <= S_CHECK;
          else                             r_set   <= r_set + 8'd1;
        end
        S_CHECK: begin
          r_err_cnt <= w_err_next;
          if (r_vec == 2'd3 && r_loops == 8'd1) begin
            // pass reflects the count including this final check
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_dut_a <= '0;
            r_dut_b <= '0;
            r_state <= S_DONE;
          end else begin
            if (r_vec == 2'd3) r_loops <= r_loops - 8'd1;
            r_vec   <= r_vec + 2'd1;
            r_state <= S_APPLY;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_a   = r_dut_a;
  assign dut_b   = r_dut_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_and2_bist_ctrl.sv
// Scoreboard bench for and2_bist_ctrl: runs are queued with model results, a monitor checks every cycle.
module tb_and2_bist_ctrl;
  localparam int N = 8;
  localparam int S = 4;
  localparam int EW = 8;
  localparam int P = S + 2;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   loops = 8'd0;
  logic [N-1:0] dut_a, dut_b, dut_y;
  logic         busy, done, pass;
  logic [EW-1:0] err_cnt;
`ifdef AND2_BIST_FAILCAP_EN
  logic [1:0]   fail_vec;
  logic [N-1:0] fail_mask;
`endif

  logic [N-1:0] sa0 = '0, sa1 = '0, glitch = '0;
  logic         free = 1'b1;
  logic         glitch_on = 1'b0;
  int           n_chk = 0, n_fail = 0, cyc = 0;

  // cell bank model: ideal AND with stuck-at faults and an optional transient glitch
  assign dut_y = (((dut_a & dut_b) & ~sa0) | sa1) ^ glitch;

  typedef struct {
    int           s0;
    int           len;
    int           err;
    bit           pas;
    logic [1:0]   fv;
    logic [N-1:0] fm;
  } run_t;
  run_t q[$];

  and2_bist_ctrl #(.N_CELLS(N), .SETTLE_CYC(S), .ERR_W(EW)) dut (
    .CLK(CLK), .RN(RN), .start(start), .loops(loops),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef AND2_BIST_FAILCAP_EN
    , .fail_vec(fail_vec), .fail_mask(fail_mask)
`endif
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic run_t model(input logic [7:0] lp, input logic [N-1:0] s0m, input logic [N-1:0] s1m);
    run_t r;
    int np, tot;
    bit got;
    logic [N-1:0] ideal, y, mm;
    np = (lp == 8'd0) ? 1 : int'(lp);
    tot = 0;
    got = 0;
    r.fv = '0;
    r.fm = '0;
    for (int p = 0; p < np; p++)
      for (int v = 0; v < 4; v++) begin
        ideal = (v == 3) ? '1 : '0;
        y     = (ideal & ~s0m) | s1m;
        mm    = y ^ ideal;
        tot  += $countones(mm);
        if (!got && mm != '0) begin
          got  = 1;
          r.fv = 2'(v);
          r.fm = mm;
        end
      end
    r.err = (tot > 255) ? 255 : tot;
    r.pas = (r.err == 0);
    r.len = np * 4 * P;
    r.s0  = 0;
    return r;
  endfunction

  // monitor: each falling edge, compare against the run at the head of the queue
  initial forever begin
    int c, slot, o, v;
    logic [N-1:0] ea, eb;
    @(negedge CLK);
    glitch = '0;
    if (q.size() == 0) begin
      if (free && RN) chk("idle", {busy, done}, 2'b00);
      else            chk("nodone", done, 1'b0);
    end else begin
      c = cyc - q[0].s0;
      if (c < 0) chk("predone", done, 1'b0);
      else if (c < q[0].len) begin
        slot = c / P;
        o    = c % P;
        v    = (o == 0) ? ((slot == 0) ? 0 : (slot - 1) % 4) : slot % 4;
        ea   = (v >= 2) ? '1 : '0;
        eb   = (v % 2 == 1) ? '1 : '0;
        chk($sformatf("run_cyc%0d_bdab", c), {busy, done, dut_a, dut_b}, {2'b10, ea, eb});
        if (glitch_on && o < P - 1) glitch = '1;
      end else begin
        chk("done_bdab", {busy, done, dut_a, dut_b}, {2'b11, {N{1'b0}}, {N{1'b0}}});
        chk("err_cnt", err_cnt, q[0].err);
        chk("pass", pass, q[0].pas);
`ifdef AND2_BIST_FAILCAP_EN
        chk("fail_vec", fail_vec, q[0].fv);
        chk("fail_mask", fail_mask, q[0].fm);
`endif
        void'(q.pop_front());
      end
    end
  end

  task automatic run(input logic [7:0] lp, input logic [N-1:0] s0m, input logic [N-1:0] s1m, input bit push);
    run_t r;
    r = model(lp, s0m, s1m);
    @(negedge CLK);
    sa0   = s0m;
    sa1   = s1m;
    loops = lp;
    start = 1'b1;
    if (push) begin
      r.s0 = cyc + 1;
      q.push_back(r);
    end
    @(negedge CLK);
    start = 1'b0;
    loops = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      chk("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset", {dut_a, dut_b, busy, done, pass, err_cnt}, '0);
    RN = 1'b1;
    repeat (2) @(negedge CLK);

    run(8'd1, '0, '0, 1);            // ideal bank
    wait_idle();
    run(8'd2, '0, 8'h08, 1);         // cell 3 stuck-at-1
    wait_idle();
    run(8'd40, '1, '0, 1);           // all stuck-at-0, saturates
    wait_idle();

    run(8'd0, '0, '0, 1);            // loops=0 and ignored re-start
    repeat (10) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge CLK);

    free = 1'b0;                     // run aborted by reset in SETTLE of vector 2
    run(8'd1, '0, '0, 0);
    repeat (14) @(negedge CLK);
    RN = 1'b0;
    #1;
    chk("abort_outs", {dut_a, dut_b, busy, done, pass, err_cnt}, '0);
    repeat (3) @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);
    free = 1'b1;
    run(8'd1, '0, '0, 1);
    wait_idle();

    glitch_on = 1'b1;                // Y glitches outside the sample point
    run(8'd2, '0, '0, 1);
    wait_idle();
    glitch_on = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run(8'($urandom_range(0, 3)), N'($urandom & $urandom), N'($urandom & $urandom & $urandom), 1);
      wait_idle();
    end
    repeat (5) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
